// File: rtl/lsu_mem_port_pkg.sv
// Shared types for the load/store memory port: FSM states, RV32I load/store
// funct3 encodings and the request classification helpers.
package lsu_mem_port_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_t;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } f3_ld_t;

    typedef enum logic [2:0] {
        F3_SB = 3'b000,
        F3_SH = 3'b001,
        F3_SW = 3'b010
    } f3_st_t;

    // funct3[1:0] gives the access size for both loads and stores
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    function automatic logic req_illegal(input logic ld, input logic st, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        if (ld) begin
            case (f3)
                F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
                default:                             ok = 1'b0;
            endcase
        end else if (st) begin
            case (f3)
                F3_SB, F3_SH, F3_SW: ok = 1'b1;
                default:             ok = 1'b0;
            endcase
        end
        return (ld == st) || !ok;
    endfunction

    function automatic logic req_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic mis;
        case (f3[1:0])
            SZ_HALF: mis = a[0];
            SZ_WORD: mis = (a != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Word-addressed memory bus between the LSU (master) and memory (slave).
interface lsu_mem_port_if;

    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/lsu_lane_fmt.sv
// Purely combinational byte-lane formatting: store byte enables and data
// shift, plus load lane extraction with sign/zero extension.
module lsu_lane_fmt
    import lsu_mem_port_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic        is_store,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    logic [7:0]  lane [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        assign lane[gi] = ld_word[8*gi +: 8];
        assign be[gi]   = !is_store                ? 1'b1 :
                          (funct3[1:0] == SZ_BYTE) ? (offset == LANE) :
                          (funct3[1:0] == SZ_HALF) ? (offset[1] == LANE[1]) :
                                                     1'b1;
    end

    always_comb begin
        wdata = '0;
        if (is_store) begin
            case (funct3[1:0])
                SZ_BYTE: wdata = st_data << {offset, 3'b000};
                SZ_HALF: wdata = offset[1] ? {st_data[15:0], 16'h0000} : st_data;
                default: wdata = st_data;
            endcase
        end
    end

    assign sel_byte = lane[offset];
    assign sel_half = offset[1] ? ld_word[31:16] : ld_word[15:0];

    always_comb begin
        ld_data = ld_word;
        case (funct3)
            F3_LB:   ld_data = {{24{sel_byte[7]}}, sel_byte};
            F3_LBU:  ld_data = {24'h000000, sel_byte};
            F3_LH:   ld_data = {{16{sel_half[15]}}, sel_half};
            F3_LHU:  ld_data = {16'h0000, sel_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Single-outstanding load/store unit memory port: accepts one pipeline request,
// runs it on the word bus (or rejects it), and returns a one-cycle response.
module lsu_mem_port
    import lsu_mem_port_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_load,
    input  logic               req_store,
    input  logic [2:0]         req_funct3,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    output logic               rsp_valid,
    output logic [31:0]        rsp_rdata,
    output logic               rsp_misaligned,
    output logic               rsp_fault,
    lsu_mem_port_if.master     mem
);

    localparam int            CW       = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_WAIT);

    lsu_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          store_q, store_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          fault_q, fault_d;
    logic          mis_q, mis_d;

    logic          in_req;
    logic          last_cycle;
    logic [3:0]    lane_be;
    logic [31:0]   lane_wdata;
    logic [31:0]   lane_rdata;

    lsu_lane_fmt u_lane (
        .funct3   (funct3_q),
        .offset   (addr_q[1:0]),
        .is_store (store_q),
        .st_data  (wdata_q),
        .ld_word  (mem.mem_rdata),
        .be       (lane_be),
        .wdata    (lane_wdata),
        .ld_data  (lane_rdata)
    );

    // This REQ/WAIT cycle is the MAX_WAIT-th one; anything unfinished now faults.
    assign last_cycle = (cnt_q >= CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            store_q  <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            fault_q  <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            store_q  <= store_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
            mis_q    <= mis_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        store_d  = store_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        fault_d  = fault_q;
        mis_d    = mis_q;

        if ((state_q == ST_REQ || state_q == ST_WAIT) && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    store_d  = req_store;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    cnt_d    = '0;
                    rdata_d  = '0;
                    fault_d  = 1'b0;
                    mis_d    = 1'b0;
                    if (req_illegal(req_load, req_store, req_funct3)) begin
                        fault_d = 1'b1;
                        state_d = ST_RESP;
                    end else if (req_misaligned(req_funct3, req_addr[1:0])) begin
                        mis_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // A load granted in its last allowed cycle cannot finish in time.
                if (mem.mem_gnt && store_q) begin
                    state_d = ST_RESP;
                end else if (last_cycle) begin
                    fault_d = 1'b1;
                    state_d = ST_RESP;
                end else if (mem.mem_gnt) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem.mem_rvalid) begin
                    rdata_d = lane_rdata;
                    state_d = ST_RESP;
                end else if (last_cycle) begin
                    fault_d = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign in_req        = (state_q == ST_REQ);
    assign req_ready     = (state_q == ST_IDLE);

    assign mem.mem_req   = in_req;
    assign mem.mem_we    = in_req & store_q;
    assign mem.mem_be    = in_req ? lane_be : 4'b0000;
    assign mem.mem_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem.mem_wdata = in_req ? lane_wdata : 32'h0;

    assign rsp_valid      = (state_q == ST_RESP);
    assign rsp_rdata      = rsp_valid ? rdata_q : 32'h0;
    assign rsp_fault      = rsp_valid & fault_q;
    assign rsp_misaligned = rsp_valid & mis_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port: directed cases plus randomized
// transactions against a cycle-count/lane-arithmetic reference model.
module tb_lsu_mem_port;

    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_load, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_misaligned, rsp_fault;
    logic [31:0] rsp_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int n_txn   = 0;

    always #5 clk = ~clk;

    lsu_mem_port_if bus();

    lsu_mem_port #(.MAX_WAIT(MW)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_load       (req_load),
        .req_store      (req_store),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_misaligned (rsp_misaligned),
        .rsp_fault      (rsp_fault),
        .mem            (bus)
    );

    typedef struct {
        int          rsp_cyc;
        logic [31:0] rdata;
        logic        fault;
        logic        mis;
        int          reqn;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [3:0]  mbe;
        logic        mwe;
        bit          unstable;
        bit          leak;
        bit          pulse_ok;
        bit          ready0;
    } obs_t;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        bit          fault;
        bit          mis;
        bit          access;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          we;
        int          reqn;
    } exp_t;

    // g = extra REQ cycles before grant, r = extra WAIT cycles before rvalid.
    function automatic exp_t ref_model(input bit ld, input bit st, input int f3,
                                       input logic [31:0] addr, input logic [31:0] wd,
                                       input logic [31:0] rd, input int g, input int r);
        exp_t        e;
        int          size, off;
        logic [31:0] v;
        e = '{default: 0};
        off = int'(addr & 32'd3);
        if (ld == st || (ld && !(f3 inside {0, 1, 2, 4, 5})) || (st && !(f3 inside {0, 1, 2}))) begin
            e.fault = 1; e.cyc = 1; return e;
        end
        size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        if (off % size != 0) begin
            e.mis = 1; e.cyc = 1; return e;
        end
        e.access = 1;
        e.addr   = addr & 32'hFFFF_FFFC;
        e.we     = st;
        e.be     = st ? 4'(((1 << size) - 1) << off) : 4'hF;
        e.wdata  = st ? (wd << (8 * off)) : 32'h0;
        e.reqn   = (g + 1 > MW) ? MW : g + 1;
        if (g + 1 > MW || (ld && g + r + 2 > MW)) begin
            e.fault = 1; e.cyc = MW + 1; return e;
        end
        if (st) begin
            e.cyc = g + 2; return e;
        end
        e.cyc = g + r + 3;
        v = rd >> (8 * off);
        if (size == 1) v = v & 32'h0000_00FF;
        else if (size == 2) v = v & 32'h0000_FFFF;
        if (f3 < 4 && size < 4 && v[8 * size - 1]) v = v - (32'd1 << (8 * size));
        e.rdata = v;
        return e;
    endfunction

    // Starts at a negedge with the DUT idle; ends at the negedge after the response.
    task automatic run_txn(input bit ld, input bit st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                           input int g, input int r, output obs_t o);
        int c, reqn, cg, plan;
        bit done;
        o = '{default: 0};
        o.rsp_cyc = -1;
        o.ready0  = req_ready;
        req_valid = 1'b1; req_load = ld; req_store = st; req_funct3 = f3;
        req_addr = addr; req_wdata = wd;
        bus.mem_gnt = 1'($urandom); bus.mem_rvalid = 1'($urandom); bus.mem_rdata = $urandom;
        @(negedge clk);
        req_valid = 1'b0; req_load = 1'($urandom); req_store = 1'($urandom);
        req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
        c = 1; reqn = 0; cg = -1; plan = -1; done = 0;
        while (!done && c < 40) begin
            if (bus.mem_req) begin
                reqn++;
                if (reqn == 1) begin
                    o.maddr = bus.mem_addr; o.mbe = bus.mem_be; o.mwe = bus.mem_we; o.mwdata = bus.mem_wdata;
                end else if (bus.mem_addr !== o.maddr || bus.mem_be !== o.mbe || bus.mem_we !== o.mwe || bus.mem_wdata !== o.mwdata) begin
                    o.unstable = 1;
                end
            end
            if (!rsp_valid && (rsp_rdata !== 32'h0 || rsp_fault !== 1'b0 || rsp_misaligned !== 1'b0)) o.leak = 1;
            if (rsp_valid) begin
                o.rsp_cyc = c; o.rdata = rsp_rdata; o.fault = rsp_fault; o.mis = rsp_misaligned; done = 1;
            end
            if (bus.mem_req) begin
                bus.mem_gnt = (reqn == g + 1);
                if (bus.mem_gnt && ld) begin cg = c; plan = c + 1 + r; end
            end else begin
                bus.mem_gnt = 1'($urandom);
            end
            if (c == plan) begin
                bus.mem_rvalid = 1'b1; bus.mem_rdata = rd;
            end else if (cg >= 0 && c > cg && c < plan) begin
                bus.mem_rvalid = 1'b0; bus.mem_rdata = $urandom;
            end else begin
                bus.mem_rvalid = 1'($urandom); bus.mem_rdata = $urandom;
            end
            @(negedge clk);
            c++;
        end
        if (done) o.pulse_ok = !rsp_valid && req_ready;
        o.reqn = reqn;
        n_txn++;
        $display("[TB] txn %0d ld=%0b st=%0b f3=%0d addr=%08h g=%0d r=%0d -> rsp_cyc=%0d rdata=%08h fault=%0b mis=%0b mem_req_cycles=%0d",
                 n_txn, ld, st, f3, addr, g, r, o.rsp_cyc, o.rdata, o.fault, o.mis, reqn);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h40; req_wdata = 32'h0;
        bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        n_tests++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got=%b exp=0", bus.mem_req); end
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        n_tests++; if ({bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata} !== 69'h0) begin n_fail++; $display("FAIL reset_mem_outputs we=%b be=%b addr=%h wdata=%h exp=all zero", bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata); end
        n_tests++; if ({rsp_rdata, rsp_fault, rsp_misaligned} !== 34'h0) begin n_fail++; $display("FAIL reset_rsp_outputs rdata=%h fault=%b mis=%b exp=all zero", rsp_rdata, rsp_fault, rsp_misaligned); end
        req_valid = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after got=%b exp=1", req_ready); end
    endtask

    task automatic test_store_sb();
        obs_t o;
        run_txn(1'b0, 1'b1, 3'b000, 32'h103, 32'h0000_00A5, 32'h0, 0, 0, o);
        n_tests++; if (o.mbe !== 4'b1000) begin n_fail++; $display("FAIL sb_be got=%b exp=1000", o.mbe); end
        n_tests++; if (o.mwdata !== 32'hA500_0000) begin n_fail++; $display("FAIL sb_wdata got=%h exp=a5000000", o.mwdata); end
        n_tests++; if (o.maddr !== 32'h100) begin n_fail++; $display("FAIL sb_addr got=%h exp=00000100", o.maddr); end
        n_tests++; if (o.mwe !== 1'b1) begin n_fail++; $display("FAIL sb_we got=%b exp=1", o.mwe); end
        n_tests++; if (o.rsp_cyc != 2) begin n_fail++; $display("FAIL sb_latency got=%0d exp=2", o.rsp_cyc); end
        n_tests++; if (o.rdata !== 32'h0 || o.fault !== 1'b0) begin n_fail++; $display("FAIL sb_rsp rdata=%h fault=%b exp=0/0", o.rdata, o.fault); end
    endtask

    task automatic test_load_ext();
        obs_t o;
        run_txn(1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 32'h0080_0000, 0, 0, o);
        n_tests++; if (o.rdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_sext got=%h exp=ffffff80", o.rdata); end
        n_tests++; if (o.rsp_cyc != 3) begin n_fail++; $display("FAIL lb_latency got=%0d exp=3", o.rsp_cyc); end
        n_tests++; if (o.mbe !== 4'hF || o.mwe !== 1'b0) begin n_fail++; $display("FAIL lb_bus be=%b we=%b exp=1111/0", o.mbe, o.mwe); end
        run_txn(1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 32'h0080_0000, 0, 0, o);
        n_tests++; if (o.rdata !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_zext got=%h exp=00000080", o.rdata); end
    endtask

    task automatic test_errors();
        obs_t o;
        run_txn(1'b1, 1'b0, 3'b010, 32'h006, 32'h0, 32'h0, 0, 0, o);
        n_tests++; if (o.mis !== 1'b1 || o.fault !== 1'b0) begin n_fail++; $display("FAIL lw_misaligned mis=%b fault=%b exp=1/0", o.mis, o.fault); end
        n_tests++; if (o.rsp_cyc != 1 || o.reqn != 0) begin n_fail++; $display("FAIL lw_mis_timing cyc=%0d mem_req_cycles=%0d exp=1/0", o.rsp_cyc, o.reqn); end
        run_txn(1'b1, 1'b1, 3'b010, 32'h010, 32'h0, 32'h0, 0, 0, o);
        n_tests++; if (o.fault !== 1'b1 || o.reqn != 0 || o.rsp_cyc != 1) begin n_fail++; $display("FAIL both_ld_st fault=%b mem_req_cycles=%0d cyc=%0d exp=1/0/1", o.fault, o.reqn, o.rsp_cyc); end
        run_txn(1'b0, 1'b1, 3'b100, 32'h010, 32'h0, 32'h0, 0, 0, o);
        n_tests++; if (o.fault !== 1'b1 || o.reqn != 0) begin n_fail++; $display("FAIL bad_store_f3 fault=%b mem_req_cycles=%0d exp=1/0", o.fault, o.reqn); end
        run_txn(1'b1, 1'b0, 3'b011, 32'h010, 32'h0, 32'h0, 0, 0, o);
        n_tests++; if (o.fault !== 1'b1 || o.reqn != 0) begin n_fail++; $display("FAIL bad_load_f3 fault=%b mem_req_cycles=%0d exp=1/0", o.fault, o.reqn); end
    endtask

    task automatic test_timeout();
        obs_t o;
        run_txn(1'b1, 1'b0, 3'b001, 32'h000, 32'h0, 32'h0, 100, 0, o);
        n_tests++; if (o.fault !== 1'b1 || o.rdata !== 32'h0) begin n_fail++; $display("FAIL lh_no_grant fault=%b rdata=%h exp=1/0", o.fault, o.rdata); end
        n_tests++; if (o.rsp_cyc < 1 || o.rsp_cyc > 6 || o.reqn != MW) begin n_fail++; $display("FAIL lh_no_grant_timing cyc=%0d mem_req_cycles=%0d exp=<=6/%0d", o.rsp_cyc, o.reqn, MW); end
        run_txn(1'b1, 1'b0, 3'b010, 32'h000, 32'h0, 32'h0, 0, 100, o);
        n_tests++; if (o.fault !== 1'b1 || o.rsp_cyc != MW + 1 || o.reqn != 1) begin n_fail++; $display("FAIL lw_no_rvalid fault=%b cyc=%0d mem_req_cycles=%0d exp=1/%0d/1", o.fault, o.rsp_cyc, o.reqn, MW + 1); end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        exp_t e;
        req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h44; req_wdata = 32'h0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        n_tests++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_req_setup mem_req=%b exp=1", bus.mem_req); end
        rst = 1'b0; #1;
        n_tests++; if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_req mem_req=%b addr=%h ready=%b exp=0/0/1", bus.mem_req, bus.mem_addr, req_ready); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        n_tests++; if (bus.mem_req !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_wait_setup mem_req=%b rsp_valid=%b ready=%b exp=0/0/0", bus.mem_req, rsp_valid, req_ready); end
        rst = 1'b0; #1;
        n_tests++; if (rsp_valid !== 1'b0 || bus.mem_req !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_wait rsp_valid=%b mem_req=%b ready=%b exp=0/0/1", rsp_valid, bus.mem_req, req_ready); end
        @(negedge clk); rst = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1234_5678;
        @(negedge clk); bus.mem_rvalid = 1'b0;
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_late_rvalid rsp_valid=%b exp=0", rsp_valid); end
        @(negedge clk);
        n_tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_idle_after rsp_valid=%b ready=%b exp=0/1", rsp_valid, req_ready); end
        e = ref_model(1'b1, 1'b0, 5, 32'h42, 32'h0, 32'h9ABC_5678, 1, 1);
        run_txn(1'b1, 1'b0, 3'b101, 32'h42, 32'h0, 32'h9ABC_5678, 1, 1, o);
        n_tests++; if (o.rdata !== e.rdata || o.rsp_cyc != e.cyc || o.fault !== 1'b0) begin n_fail++; $display("FAIL rst_next_req rdata=%h cyc=%0d fault=%b exp=%h/%0d/0", o.rdata, o.rsp_cyc, o.fault, e.rdata, e.cyc); end
    endtask

    task automatic test_random(input int n);
        obs_t        o;
        exp_t        e;
        bit          ld, st;
        logic [2:0]  f3;
        logic [31:0] addr, wd, rd;
        int          g, r, kind;
        for (int i = 0; i < n; i++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) begin ld = 1'($urandom); st = ld; end
            else begin ld = (kind < 6); st = !ld; end
            f3   = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2)) | (ld && $urandom_range(0, 1) == 1 ? 3'b100 : 3'b000);
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            wd = $urandom; rd = $urandom;
            g = $urandom_range(0, 4); r = $urandom_range(0, 3);
            e = ref_model(ld, st, int'(f3), addr, wd, rd, g, r);
            run_txn(ld, st, f3, addr, wd, rd, g, r, o);
            n_tests++; if (o.rsp_cyc != e.cyc) begin n_fail++; $display("FAIL rnd_latency i=%0d got=%0d exp=%0d", i, o.rsp_cyc, e.cyc); end
            n_tests++; if (o.rdata !== e.rdata) begin n_fail++; $display("FAIL rnd_rdata i=%0d got=%h exp=%h", i, o.rdata, e.rdata); end
            n_tests++; if (o.fault !== e.fault || o.mis !== e.mis) begin n_fail++; $display("FAIL rnd_flags i=%0d fault=%b mis=%b exp=%b/%b", i, o.fault, o.mis, e.fault, e.mis); end
            n_tests++; if (o.reqn != e.reqn) begin n_fail++; $display("FAIL rnd_mem_req_cycles i=%0d got=%0d exp=%0d", i, o.reqn, e.reqn); end
            n_tests++; if (!o.ready0 || !o.pulse_ok || o.leak || o.unstable) begin n_fail++; $display("FAIL rnd_protocol i=%0d ready=%b pulse_ok=%b leak=%b unstable=%b exp=1/1/0/0", i, o.ready0, o.pulse_ok, o.leak, o.unstable); end
            if (e.access && o.reqn > 0) begin
                n_tests++; if (o.maddr !== e.addr || o.mbe !== e.be || o.mwe !== e.we) begin n_fail++; $display("FAIL rnd_bus i=%0d addr=%h be=%b we=%b exp=%h/%b/%b", i, o.maddr, o.mbe, o.mwe, e.addr, e.be, e.we); end
                if (e.we) begin
                    n_tests++; if (o.mwdata !== e.wdata) begin n_fail++; $display("FAIL rnd_wdata i=%0d got=%h exp=%h", i, o.mwdata, e.wdata); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_sb();
        test_load_ext();
        test_errors();
        test_timeout();
        test_reset_mid();
        test_random(200);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog sim time exceeded tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lsu_mem_port.md
LSU_MEM_PORT -- requirements
Module: lsu_mem_port

Parameters
REQ-001 SHALL provide MAX_WAIT, default 255: the maximum number of cycles spent in REQ plus WAIT before a timeout fault.

Interface
REQ-002 SHALL have clk, input, 1: the single clock, rising-edge.
REQ-003 SHALL have rst, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have req_valid/req_ready, input/output, 1 each: pipeline request handshake.
REQ-005 SHALL have req_load, req_store, input, 1 each: access type.
REQ-006 SHALL have req_funct3, input, 3: the RV32I load/store funct3.
REQ-007 SHALL have req_addr and req_wdata, input, 32 each: byte address and store data (data is LSB-aligned).
REQ-008 SHALL have rsp_valid, output, 1: a one-cycle completion pulse.
REQ-009 SHALL have rsp_rdata, output, 32: the extended load result.
REQ-010 SHALL have rsp_misaligned and rsp_fault, output, 1 each: error flags, qualified by rsp_valid.
REQ-011 SHALL have mem_req, output, 1, and mem_gnt, input, 1: memory request and grant.
REQ-012 SHALL have mem_we, output, 1, and mem_be, output, 4: write enable and byte enables.
REQ-013 SHALL have mem_addr and mem_wdata, output, 32 each: word address (bits [1:0] = 0) and lane-shifted write data.
REQ-014 SHALL have mem_rvalid, input, 1, and mem_rdata, input, 32: raw read word return.

Function
REQ-015 SHALL implement the states IDLE, REQ, WAIT and RESP; req_ready = 1 only in IDLE.
REQ-016 Accept: in IDLE, req_valid && req_ready SHALL capture all request fields into registers.
REQ-017 Illegal request SHALL go to RESP with rsp_fault = 1 and no memory access. Illegal means:
- load == store, or
- funct3 invalid for the access type (load: LB/LH/LW/LBU/LHU; store: SB/SH/SW).
REQ-018 Misaligned request SHALL go to RESP with rsp_misaligned = 1 and no memory access. Misaligned means:
- half access with addr[0] = 1, or
- word access with addr[1:0] != 0.
REQ-019 A legal access SHALL go to REQ with mem_req = 1.
- mem_addr, mem_be, mem_we and mem_wdata SHALL be held stable until the grant.
REQ-020 mem_be and mem_wdata SHALL follow these lane rules:
- SB: be = 1 << addr[1:0], wdata = wdata << 8*addr[1:0].
- SH: be = 0011 or 1100 per addr[1], data shifted 16 for the upper half.
- SW: be = 1111.
- Loads: be = 1111, mem_we = 0.
REQ-021 A store with mem_req && mem_gnt SHALL go to RESP, drop mem_req the next cycle, and return rsp_rdata = 0.
REQ-022 A load with mem_req && mem_gnt SHALL go to WAIT and drop mem_req.
- mem_rvalid in the grant cycle itself SHALL be ignored.
REQ-023 In WAIT, mem_rvalid SHALL register the extracted, extended lane into rsp_rdata and go to RESP.
- LB/LBU take byte addr[1:0].
- LH/LHU take half addr[1].
- Sign- or zero-extend per funct3.
REQ-024 RESP SHALL assert rsp_valid for exactly one cycle, then go to IDLE.
REQ-025 Minimum latency, with accept at cycle 0:
- Store: rsp_valid at cycle 2 (grant at cycle 1).
- Load: rsp_valid at cycle 3 (rvalid at cycle 2).
- Error: rsp_valid at cycle 1.
REQ-026 A saturating wait counter SHALL clear on accept and increment each cycle in REQ or WAIT.
- On reaching MAX_WAIT it SHALL go to RESP with rsp_fault = 1 and rsp_rdata = 0, and drop mem_req.
REQ-027 Stray inputs SHALL be ignored:
- mem_gnt while mem_req = 0.
- mem_rvalid outside WAIT.
REQ-028 When not in RESP, rsp_rdata, rsp_fault and rsp_misaligned SHALL be 0.

Reset
REQ-029 rst = 0 SHALL immediately force the following, regardless of any outstanding access:
- state IDLE and counter 0;
- mem_req = 0, rsp_valid = 0, and all response outputs 0;
- mem_we = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0.
REQ-030 After rst deasserts, req_ready SHALL be 1 on the first clock edge.

Structure
REQ-031 The shared package SHALL hold the f3Ld/f3St funct3 constants and the lsu_state_t enum.
REQ-032 Lane logic (be, shift, extract/extend) SHALL live in a sub-module lsu_lane_fmt that contains no registers.

Verification
REQ-033 SB at addr 0x103, wdata 0x000000A5, grant at cycle 1:
- be = 1000, mem_wdata = 0xA5000000, mem_addr = 0x100, rsp_valid at cycle 2.
REQ-034 LB at 0x102, mem_rdata = 0x00800000, rvalid one cycle after grant:
- rsp_rdata = 0xFFFFFF80; the same access as LBU gives 0x00000080.
REQ-035 LW at 0x006:
- rsp_misaligned = 1 at cycle 1; mem_req never asserts.
REQ-036 Both req_load = 1 and req_store = 1:
- rsp_fault = 1, no memory access.
REQ-037 LH at 0x000 with mem_gnt held low, MAX_WAIT = 4:
- rsp_fault = 1 and mem_req drops by cycle 6.
REQ-038 rst pulled low while in WAIT:
- mem_req and rsp_valid are 0 immediately; a later rvalid is ignored; the next request is accepted normally.
